exec_stage: RTL
===============

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clk.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  decoder presents an instruction this cycle.
REQ-005 in_ready  out  1  stage can accept an instruction this cycle.
REQ-006 op  in  4  operation code (see REQ-012).
REQ-007 dst, src_a, src_b  in  4 each  destination and source register addresses; src_a/src_b also drive the register file read ports.
REQ-008 rd_a, rd_b  in  8 each  register file read data for src_a and src_b (combinational read).
REQ-009 wr_en, wr_addr, wr_data  out  1/4/8  register file write port: write enable, address, value.
REQ-010 flags  out  3  {N,C,Z} condition register.
REQ-011 busy  out  1  multiply in progress.

Function
REQ-012 Opcodes SHALL be 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR, 8 MOV (result = B), 9 CMP (A-B, flags only), A MUL (low byte of A*B); B-F SHALL behave as NOP.
REQ-013 An instruction SHALL be accepted on a rising edge where in_valid && in_ready; in_valid with in_ready low SHALL be ignored (the decoder holds it).
REQ-014 Operand forwarding: if wr_en is high and wr_addr equals src_a (src_b) in the accept cycle, operand A (B) SHALL be wr_data instead of rd_a (rd_b).
REQ-015 Single-cycle ops (ADD..MOV) SHALL drive wr_en=1, wr_addr=dst, wr_data=result for exactly the one cycle after acceptance; NOP, CMP and reserved codes SHALL leave wr_en=0.
REQ-016 Arithmetic SHALL be 8-bit modulo 256; SHL/SHR SHALL shift by one with zero fill.
REQ-017 Flags SHALL update at the same edge the result registers: Z=(result==0), N=result[7]; C = carry-out (ADD), borrow A<B unsigned (SUB/CMP), bit shifted out (SHL bit7, SHR bit0), 0 (AND/OR/XOR), unchanged (MOV); NOP/reserved SHALL leave flags unchanged.
REQ-018 FSM states SHALL be IDLE and MUL; in_ready=1 only in IDLE; busy=1 only in MUL.
REQ-019 IDLE->MUL on accepting MUL; operands latched (after forwarding) at accept.
REQ-020 MUL SHALL run a shift-add loop of exactly 8 iterations, counter 0..7, one per cycle; on the edge with counter==7 the state SHALL return to IDLE and the result, write fields and flags SHALL register, so that wr_en is high in the first IDLE cycle (9 cycles after acceptance).
REQ-021 MUL flags: Z,N from low byte; C=1 iff the high byte of the 16-bit product is non-zero.
REQ-022 An instruction accepted in the cycle wr_en is high SHALL be valid and SHALL use forwarding per REQ-014; back-to-back single-cycle ops SHALL sustain one per cycle.
REQ-023 Writes to any address including 15 (memory register) SHALL be permitted without special handling.

Reset
REQ-024 On reset the state SHALL be IDLE, counter 0, wr_en=0, wr_addr=0, wr_data=0, flags=0, busy=0, and in_ready SHALL be 1 in the first cycle after reset.
REQ-025 Reset during MUL SHALL abort the multiply with no register file write and no flag update.
REQ-026 in_valid asserted during reset SHALL be discarded.

Structure
REQ-027 A shared package exec_pkg SHALL hold the opcode enum, the FSM state enum and the flag bit index constants (Z=0, C=1, N=2).
REQ-028 The multiplier datapath SHALL be one sub-module mul_seq (start, a, b -> 16-bit product, done); all other logic SHALL remain in exec_stage.

Verification
REQ-029 ADD src_a=R1=0xF0, src_b=R2=0x20, dst=R3 -> next cycle wr_en=1, wr_addr=3, wr_data=0x10, flags Z=0,C=1,N=0.
REQ-030 CMP R1=0x05, R2=0x05 -> wr_en stays 0; flags Z=1,C=0,N=0.
REQ-031 ADD R3<=R1+R2 (0x01+0x02) then next cycle ADD R4<=R3+R3 -> second write wr_data=0x06 via forwarding.
REQ-032 MUL R1=0x10, R2=0x20 -> in_ready low 8 cycles, busy high 8 cycles, wr_en 9 cycles after accept with wr_data=0x00, Z=1, C=1.
REQ-033 Reset asserted 4 cycles into MUL -> no wr_en, flags=0, in_ready=1 the cycle after reset deasserts.
REQ-034 SHR R5=0x81 then SHL R6=0x80 -> wr_data 0x40 with C=1, then 0x00 with Z=1, C=1.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: opcodes, FSM states and flag bit positions.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_MOV = 4'h8,
    OP_CMP = 4'h9,
    OP_MUL = 4'hA
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  // Packs N/C/Z for a result byte into the condition register layout.
  function automatic logic [2:0] make_flags(input logic [7:0] res, input logic c);
    logic [2:0] f;
    f         = '0;
    f[FLAG_Z] = (res == 8'd0);
    f[FLAG_C] = c;
    f[FLAG_N] = res[7];
    return f;
  endfunction

endpackage

// File: rtl/exec_mul_seq.sv
// Shift-add 8x8 multiplier: one partial product per cycle, eight cycles per product.
module mul_seq
  import exec_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product,
  output logic        done
);

  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [15:0] acc;
  logic [15:0] acc_next;
  logic [2:0]  cnt;
  logic        running;

  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : 16'd0);
  end

  // product is the accumulator after this cycle's step, valid while done is high
  assign product = acc_next;
  assign done    = running && (cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= 3'd0;
      acc     <= 16'd0;
      mcand   <= 16'd0;
      mplier  <= 8'd0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= 3'd0;
      acc     <= 16'd0;
      mcand   <= {8'd0, a};
      mplier  <= b;
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 3'd1;
      if (cnt == 3'd7) running <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU ops with write-port forwarding, plus a sequential MUL.
// Handshake: an instruction is taken on a rising edge where in_valid && in_ready; the decoder holds it otherwise.
module exec_stage
  import exec_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] op,
  input  logic [3:0] dst,
  input  logic [3:0] src_a,
  input  logic [3:0] src_b,
  input  logic [7:0] rd_a,
  input  logic [7:0] rd_b,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [2:0] flags,
  output logic       busy
);

  state_e      state;
  opcode_e     opc;
  logic        accept;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic [8:0]  sum9;
  logic [8:0]  diff9;
  logic [7:0]  res;
  logic        c_out;
  logic        do_wr;
  logic        do_flags;
  logic [3:0]  mul_dst;
  logic        mul_start;
  logic [15:0] mul_product;
  logic        mul_done;

  assign opc      = opcode_e'(op);
  assign in_ready = (state == ST_IDLE);
  assign busy     = (state == ST_MUL);
  assign accept   = in_valid && in_ready;

  // The result being written this cycle is newer than the register file read.
  assign opa = (wr_en && (wr_addr == src_a)) ? wr_data : rd_a;
  assign opb = (wr_en && (wr_addr == src_b)) ? wr_data : rd_b;

  assign sum9      = {1'b0, opa} + {1'b0, opb};
  assign diff9     = {1'b0, opa} - {1'b0, opb};
  assign mul_start = accept && (opc == OP_MUL);

  always_comb begin
    res      = 8'd0;
    c_out    = flags[FLAG_C];
    do_wr    = 1'b0;
    do_flags = 1'b0;
    case (opc)
      OP_ADD: begin res = sum9[7:0];  c_out = sum9[8];  do_wr = 1'b1; do_flags = 1'b1; end
      OP_SUB: begin res = diff9[7:0]; c_out = diff9[8]; do_wr = 1'b1; do_flags = 1'b1; end
      OP_AND: begin res = opa & opb;  c_out = 1'b0;     do_wr = 1'b1; do_flags = 1'b1; end
      OP_OR:  begin res = opa | opb;  c_out = 1'b0;     do_wr = 1'b1; do_flags = 1'b1; end
      OP_XOR: begin res = opa ^ opb;  c_out = 1'b0;     do_wr = 1'b1; do_flags = 1'b1; end
      OP_SHL: begin res = {opa[6:0], 1'b0}; c_out = opa[7]; do_wr = 1'b1; do_flags = 1'b1; end
      OP_SHR: begin res = {1'b0, opa[7:1]}; c_out = opa[0]; do_wr = 1'b1; do_flags = 1'b1; end
      OP_MOV: begin res = opb; do_wr = 1'b1; do_flags = 1'b1; end
      OP_CMP: begin res = diff9[7:0]; c_out = diff9[8]; do_flags = 1'b1; end
      default: begin end
    endcase
  end

  mul_seq u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (opa),
    .b       (opb),
    .product (mul_product),
    .done    (mul_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      wr_en   <= 1'b0;
      wr_addr <= 4'd0;
      wr_data <= 8'd0;
      flags   <= 3'd0;
      mul_dst <= 4'd0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (opc == OP_MUL) begin
              state   <= ST_MUL;
              mul_dst <= dst;
            end else begin
              wr_en <= do_wr;
              if (do_wr) begin
                wr_addr <= dst;
                wr_data <= res;
              end
              if (do_flags) flags <= make_flags(res, c_out);
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state   <= ST_IDLE;
            wr_en   <= 1'b1;
            wr_addr <= mul_dst;
            wr_data <= mul_product[7:0];
            flags   <= make_flags(mul_product[7:0], |mul_product[15:8]);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
